pmc_matrix_shifter: RTL
=======================

// Module: pmc_matrix_shifter
// PURPOSE
//  Parametrised bit-serial shift engine between PMC dout/din registers and the pixel matrix.
//  Shifts NUM_CH lanes of SHIFT_LEN bits MSB-first into the matrix on generated clk_sh.
//  Simultaneously captures NUM_CH return lanes into din. Programmable bit count and clk_sh rate.
//  Sits between the PMC register file / coprocessor and the matrix pads; replaces fixed 16x32 sequencing.
// PARAMETERS
//  NUM_CH     16  parallel data lanes (dout/din words)
//  SHIFT_LEN  32  shift register length per lane, bits (>=2)
//  CNT_W      $clog2(SHIFT_LEN)+1  width of bit_cnt / internal bit counter
// PORTS
//  clk        in   1                  system clock
//  rst_n      in   1                  asynchronous active-low reset
//  start      in   1                  1-cycle request; ignored while busy
//  abort      in   1                  cancel transfer in progress
//  bit_cnt    in   CNT_W              bits to shift; 0 or >SHIFT_LEN => SHIFT_LEN
//  clk_div    in   8                  clk_sh half-period = clk_div+1 clk cycles
//  dout       in   NUM_CH*SHIFT_LEN   lane ch = dout[ch*SHIFT_LEN +: SHIFT_LEN]
//  din        out  NUM_CH*SHIFT_LEN   captured result, same lane packing
//  busy       out  1                  transfer active
//  done       out  1                  1-cycle pulse at completion
//  clk_sh     out  1                  matrix shift clock
//  sh_data_o  out  NUM_CH             serial data to matrix, lane MSB
//  sh_data_i  in   NUM_CH             serial data from matrix
// BEHAVIOUR
//  Reset: state IDLE; busy, done, clk_sh, sh_data_o = 0; din = 0; all counters 0.
//  States: IDLE -> LOW -> HIGH -> (LOW | FIN) -> IDLE; D = clk_div+1, n = effective bit count.
//  IDLE: start=1 and abort=0 sampled at cycle 0 -> latch dout into lane SRs, n, D; LOW from cycle 1.
//  LOW: clk_sh=0 for D cycles; sh_data_o[ch] = SR[ch][SHIFT_LEN-1] throughout.
//  LOW->HIGH: on the edge clk_sh is driven 1, register sh_data_i (no synchroniser; matrix is synchronous).
//  HIGH: clk_sh=1 for D cycles. HIGH exit: SR[ch] <= {SR[ch][SHIFT_LEN-2:0], sample[ch]}; bit counter+1.
//  If bit counter == n after shift -> FIN, else -> LOW.
//  FIN (1 cycle): din <= SRs, done=1, busy=0; next cycle IDLE.
//  Latency: done high exactly 2*n*D+1 cycles after start sampled; busy high cycles 1..2*n*D.
//  n<SHIFT_LEN: din lane = {dout lane[SHIFT_LEN-1-n:0], n captured bits}.
//  clk_div=0: clk_sh period 2 clk; clk_div=255: period 512 clk. D counter 9 bits, never wraps.
//  start while busy: ignored, no queuing. start and abort same cycle in IDLE: start ignored.
//  abort while busy: next cycle IDLE, clk_sh=0, sh_data_o=0, busy=0, no done, din unchanged.
//  bit_cnt/clk_div/dout changes mid-transfer: no effect (latched at start).
//  Async reset mid-transfer: immediate return to reset values, din cleared.
// CONFIGURATION
//  PMC_MATRIX_SHIFTER_STROBE_EN defined: adds input strobe_len[7:0] and output strobe (reset 0).
//   HIGH exit on last bit -> STROBE state: strobe=1, clk_sh=0 for strobe_len cycles, then FIN.
//   strobe_len=0 skips STROBE; done latency becomes 2*n*D+strobe_len+1; abort in STROBE drops strobe.
//  Not defined: ports strobe_len/strobe absent, no STROBE state, timing as above.
// TESTING
//  1 Reset: rst_n=0 mid-transfer -> busy,done,clk_sh,sh_data_o,din all 0 same cycle.
//  2 NUM_CH=16, SHIFT_LEN=32, bit_cnt=0, clk_div=0, sh_data_o looped to sh_data_i -> done
//    at cycle 65, din==dout, 32 clk_sh pulses each 2 clk period.
//  3 Lane0 dout=32'hA5A5_0000, bit_cnt=8, clk_div=3, sh_data_i[0]=1 -> sh_data_o[0] = 1,0,1,0,0,1,0,1;
//    done at cycle 65; din lane0 = 32'hA500_00FF.
//  4 abort asserted at cycle 10 of a 32-bit transfer -> busy=0 cycle 11, no done, din keeps old value;
//    new start at cycle 12 accepted.
//  5 start pulsed during busy and bit_cnt=40 (clamps to 32) -> single transfer, exactly 32 pulses.
//  6 STROBE_EN, strobe_len=5, bit_cnt=4, clk_div=0 -> strobe high cycles 9..13, done at cycle 14.

Source files
------------

// File: rtl/pmc_matrix_shifter.sv
// Bit-serial shift engine that moves NUM_CH lanes MSB-first between the PMC dout/din words and the pixel matrix.
// Optional post-shift strobe phase is enabled by defining PMC_MATRIX_SHIFTER_STROBE_EN.
module pmc_matrix_shifter #(
  parameter int NUM_CH    = 16,
  parameter int SHIFT_LEN = 32,
  parameter int CNT_W     = $clog2(SHIFT_LEN) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            bit_cnt,
  input  logic [7:0]                  clk_div,
  input  logic [NUM_CH*SHIFT_LEN-1:0] dout,
  output logic [NUM_CH*SHIFT_LEN-1:0] din,
  output logic                        busy,
  output logic                        done,
  output logic                        clk_sh,
  output logic [NUM_CH-1:0]           sh_data_o,
  input  logic [NUM_CH-1:0]           sh_data_i
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
  ,
  input  logic [7:0]                  strobe_len,
  output logic                        strobe
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOW    = 3'd1;
  localparam logic [2:0] ST_HIGH   = 3'd2;
  localparam logic [2:0] ST_FIN    = 3'd3;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
  localparam logic [2:0] ST_STROBE = 3'd4;
`endif

  logic [2:0]                       state_q, state_d;
  logic [NUM_CH-1:0][SHIFT_LEN-1:0] sr_q, sr_d, sr_shift;
  logic [NUM_CH*SHIFT_LEN-1:0]      din_q, din_d;
  logic [7:0]                       div_q, div_d;
  logic [CNT_W-1:0]                 n_q, n_d, bits_q, bits_d, bits_inc, n_eff;
  logic [8:0]                       phase_q, phase_d, phase_inc;
  logic                             phase_last;
  logic [NUM_CH-1:0]                sample_q, sample_d, sr_msb;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
  logic [7:0]                       slen_q, slen_d;
`endif

  // Out-of-range bit counts (0 or longer than the register) mean a full-length shift.
  assign n_eff = (bit_cnt == '0 || bit_cnt > CNT_W'(SHIFT_LEN)) ? CNT_W'(SHIFT_LEN) : bit_cnt;

  assign bits_inc   = bits_q + CNT_W'(1);
  assign phase_inc  = phase_q + 9'd1;
  // The phase counter is 9 bits so a 256-cycle half period (clk_div=255) fits without wrapping.
  assign phase_last = (phase_q == {1'b0, div_q});

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sr_shift[ch] = {sr_q[ch][SHIFT_LEN-2:0], sample_q[ch]};
      sr_msb[ch]   = sr_q[ch][SHIFT_LEN-1];
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    sr_d     = sr_q;
    din_d    = din_q;
    div_d    = div_q;
    n_d      = n_q;
    bits_d   = bits_q;
    phase_d  = phase_q;
    sample_d = sample_q;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
    slen_d   = slen_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOW;
          sr_d    = dout;
          div_d   = clk_div;
          n_d     = n_eff;
          bits_d  = '0;
          phase_d = '0;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
          slen_d  = strobe_len;
`endif
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (phase_last) begin
          state_d  = ST_HIGH;
          phase_d  = '0;
          sample_d = sh_data_i;
        end else begin
          phase_d = phase_inc;
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (phase_last) begin
          phase_d = '0;
          sr_d    = sr_shift;
          bits_d  = bits_inc;
          if (bits_inc == n_q) begin
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
            if (slen_q != 8'd0) begin
              state_d = ST_STROBE;
            end else begin
              state_d = ST_FIN;
              din_d   = sr_shift;
            end
`else
            state_d = ST_FIN;
            din_d   = sr_shift;
`endif
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_inc;
        end
      end
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
      ST_STROBE: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (phase_inc == {1'b0, slen_q}) begin
          state_d = ST_FIN;
          phase_d = '0;
          din_d   = sr_q;
        end else begin
          phase_d = phase_inc;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      // NOTE: the lane registers are ordinary flops, not RAM, so they take the async reset like the rest.
      sr_q     <= '0;
      din_q    <= '0;
      div_q    <= '0;
      n_q      <= '0;
      bits_q   <= '0;
      phase_q  <= '0;
      sample_q <= '0;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
      slen_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge value of every other one.
      state_q  <= state_d;
      sr_q     <= sr_d;
      din_q    <= din_d;
      div_q    <= div_d;
      n_q      <= n_d;
      bits_q   <= bits_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
      slen_q   <= slen_d;
`endif
    end
  end

  // Data is only presented to the pads while the shift clock is running.
  assign sh_data_o = (state_q == ST_LOW || state_q == ST_HIGH) ? sr_msb : '0;
  assign clk_sh    = (state_q == ST_HIGH);
  assign done      = (state_q == ST_FIN);
  assign din       = din_q;
`ifdef PMC_MATRIX_SHIFTER_STROBE_EN
  assign strobe    = (state_q == ST_STROBE);
  assign busy      = (state_q == ST_LOW || state_q == ST_HIGH || state_q == ST_STROBE);
`else
  assign busy      = (state_q == ST_LOW || state_q == ST_HIGH);
`endif

endmodule
